// File: rtl/temporizador_preset_if.sv
// Bus between the phase controller / display side and temporizador_preset.
// master drives tick/carrega/estado/caso_esp; slave returns the BCD count and status.
interface temporizador_preset_if #(
  parameter int EST_W = 2
);
  logic             tick;
  logic             carrega;
  logic [EST_W-1:0] estado;
  logic             caso_esp;
  logic [3:0]       unid;
  logic [3:0]       dez;
  logic             contando;
  logic             fim;

  modport master (
    output tick, carrega, estado, caso_esp,
    input  unid, dez, contando, fim
  );

  modport slave (
    input  tick, carrega, estado, caso_esp,
    output unid, dez, contando, fim
  );
endinterface

// File: rtl/temporizador_preset.sv
// Per-state two-digit BCD countdown timer with a built-in preset table.
// Define RECARGA_AUTO_EN to make FIM reload the current preset (periodic mode).
module temporizador_preset #(
  parameter int                 N_EST       = 4,
  parameter int                 EST_W       = 2,
  parameter logic [8*N_EST-1:0] PRESET_NORM = {8'h05, 8'h30, 8'h15, 8'h10},
  parameter logic [8*N_EST-1:0] PRESET_ESP  = {8'h05, 8'h15, 8'h22, 8'h10}
) (
  input  logic                 clk,
  input  logic                 rst,
  temporizador_preset_if.slave bus
);

  localparam int N_IDX = 1 << EST_W;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONTA  = 2'd1,
    FIM    = 2'd2
  } fase_t;

  fase_t      fase_reg, fase_next;
  logic [3:0] unid_reg, unid_next;
  logic [3:0] dez_reg,  dez_next;

  // Tables cover every encodable estado so the lookup needs no range check;
  // indices at or beyond N_EST hold 00.
  logic [7:0] tab_norm [N_IDX];
  logic [7:0] tab_esp  [N_IDX];
  logic [7:0] preset_sel;
  logic       count_zero;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  generate
    for (genvar gi = 0; gi < N_IDX; gi++) begin : g_tab
      if (gi < N_EST) begin : g_valid
        assign tab_norm[gi] = {clamp_bcd(PRESET_NORM[8*gi+4 +: 4]),
                               clamp_bcd(PRESET_NORM[8*gi   +: 4])};
        assign tab_esp[gi]  = {clamp_bcd(PRESET_ESP[8*gi+4 +: 4]),
                               clamp_bcd(PRESET_ESP[8*gi   +: 4])};
      end else begin : g_void
        assign tab_norm[gi] = 8'h00;
        assign tab_esp[gi]  = 8'h00;
      end
    end
  endgenerate

  assign preset_sel = bus.caso_esp ? tab_esp[bus.estado] : tab_norm[bus.estado];
  assign count_zero = (unid_reg == 4'd0) && (dez_reg == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fase_reg <= OCIOSO;
      unid_reg <= 4'd0;
      dez_reg  <= 4'd0;
    end else begin
      fase_reg <= fase_next;
      unid_reg <= unid_next;
      dez_reg  <= dez_next;
    end
  end

  always_comb begin
    fase_next = fase_reg;
    unid_next = unid_reg;
    dez_next  = dez_reg;

    case (fase_reg)
      OCIOSO: begin
        fase_next = OCIOSO;
      end
      CONTA: begin
        // Zero is checked before tick so the count can never borrow below 00.
        if (count_zero) begin
          fase_next = FIM;
        end else if (bus.tick) begin
          if (unid_reg == 4'd0) begin
            unid_next = 4'd9;
            dez_next  = dez_reg - 4'd1;
          end else begin
            unid_next = unid_reg - 4'd1;
          end
        end
      end
      FIM: begin
        unid_next = 4'd0;
        dez_next  = 4'd0;
`ifdef RECARGA_AUTO_EN
        fase_next = CONTA;
        {dez_next, unid_next} = preset_sel;
`else
        fase_next = OCIOSO;
`endif
      end
      default: begin
        fase_next = OCIOSO;
        unid_next = 4'd0;
        dez_next  = 4'd0;
      end
    endcase

    // A load overrides whatever the current phase decided, including a tick.
    if (bus.carrega) begin
      fase_next = CONTA;
      {dez_next, unid_next} = preset_sel;
    end
  end

  assign bus.unid     = unid_reg;
  assign bus.dez      = dez_reg;
  assign bus.contando = (fase_reg == CONTA);
  assign bus.fim      = (fase_reg == FIM);

endmodule

// File: tb/tb_temporizador_preset.sv
// Scoreboard bench for temporizador_preset: default-table instance plus a
// second instance with out-of-range BCD presets and a 3-bit estado.
module tb_temporizador_preset;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  temporizador_preset_if #(.EST_W(2)) main_if ();
  temporizador_preset_if #(.EST_W(3)) alt_if ();

  temporizador_preset dut (
    .clk (clk),
    .rst (rst),
    .bus (main_if)
  );

  temporizador_preset #(
    .N_EST       (4),
    .EST_W       (3),
    .PRESET_NORM ({8'h05, 8'h30, 8'h15, 8'hAF}),
    .PRESET_ESP  ({8'h05, 8'h7C, 8'h22, 8'h10})
  ) dut_alt (
    .clk (clk),
    .rst (rst),
    .bus (alt_if)
  );

  typedef struct packed {
    logic [3:0] dez;
    logic [3:0] unid;
    logic       contando;
    logic       fim;
  } obs_t;

  typedef struct packed {
    logic       r;
    logic       t;
    logic       c;
    logic [2:0] e;
    logic       s;
    obs_t       x;
  } row_t;

  obs_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic row_t mk(bit r, bit t, bit c, int e, bit s,
                              int dz, int un, bit ct, bit fm);
    row_t m;
    m.r = r; m.t = t; m.c = c; m.e = 3'(e); m.s = s;
    m.x.dez = 4'(dz); m.x.unid = 4'(un); m.x.contando = ct; m.x.fim = fm;
    return m;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_main(row_t m);
    rst              = m.r;
    main_if.tick     = m.t;
    main_if.carrega  = m.c;
    main_if.estado   = m.e[1:0];
    main_if.caso_esp = m.s;
    sb.push_back(m.x);
  endtask

  task automatic apply_alt(row_t m);
    rst             = m.r;
    alt_if.tick     = m.t;
    alt_if.carrega  = m.c;
    alt_if.estado   = m.e;
    alt_if.caso_esp = m.s;
    sb.push_back(m.x);
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL reset[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_count_norm();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 2, 0, 3, 0, 1, 0));
    for (int k = 1; k <= 30; k++)
      rows.push_back(mk(0, 1, 0, 2, 0, (30 - k) / 10, (30 - k) % 10, 1, 0));
    rows.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 1));
`ifdef RECARGA_AUTO_EN
    rows.push_back(mk(0, 0, 0, 2, 0, 3, 0, 1, 0));
`else
    rows.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0));
`endif
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL count_norm[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_esp_sampling();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 1, 1, 2, 2, 1, 0));
    rows.push_back(mk(0, 1, 0, 3, 1, 2, 1, 1, 0));
    rows.push_back(mk(0, 1, 0, 3, 0, 2, 0, 1, 0));
    rows.push_back(mk(0, 1, 0, 3, 0, 1, 9, 1, 0));
    rows.push_back(mk(0, 0, 0, 3, 0, 1, 9, 1, 0));
    rows.push_back(mk(0, 1, 1, 3, 1, 0, 5, 1, 0));
    rows.push_back(mk(0, 1, 0, 3, 1, 0, 4, 1, 0));
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL esp_sampling[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0));
    for (int k = 1; k <= 10; k++)
      rows.push_back(mk(0, 1, 0, 0, 0, 0, 10 - k, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 1, 1, 2, 2, 1, 0));
    rows.push_back(mk(0, 1, 0, 1, 1, 2, 1, 1, 0));
    rows.push_back(mk(0, 0, 1, 2, 1, 1, 5, 1, 0));
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL back_to_back[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_rst_mid();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 1, 0, 1, 5, 1, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 1, 4, 1, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 1, 3, 1, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 1, 2, 1, 0));
    rows.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL rst_mid[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_auto_reload();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 3, 0, 0, 5, 1, 0));
    for (int k = 1; k <= 5; k++)
      rows.push_back(mk(0, 1, 0, 3, 0, 0, 5 - k, 1, 0));
    rows.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 1));
`ifdef RECARGA_AUTO_EN
    rows.push_back(mk(0, 0, 0, 3, 0, 0, 5, 1, 0));
    rows.push_back(mk(0, 1, 0, 3, 0, 0, 4, 1, 0));
`else
    rows.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0));
`endif
    foreach (rows[i]) begin
      apply_main(rows[i]);
      clk1();
      got  = {main_if.dez, main_if.unid, main_if.contando, main_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL auto_reload[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  task automatic test_clamp_range();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(mk(0, 0, 1, 0, 0, 9, 9, 1, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 9, 8, 1, 0));
    rows.push_back(mk(0, 0, 1, 2, 1, 7, 9, 1, 0));
    rows.push_back(mk(0, 0, 1, 5, 0, 0, 0, 1, 0));
    rows.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 1));
`ifdef RECARGA_AUTO_EN
    rows.push_back(mk(0, 0, 0, 5, 0, 0, 0, 1, 0));
`else
    rows.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0));
`endif
    foreach (rows[i]) begin
      apply_alt(rows[i]);
      clk1();
      got  = {alt_if.dez, alt_if.unid, alt_if.contando, alt_if.fim};
      want = sb.pop_front();
      total++;
      if (got !== want)
        $display("FAIL clamp_range[%0d]: got count=%h%h contando=%b fim=%b, expected count=%h%h contando=%b fim=%b",
                 i, got.dez, got.unid, got.contando, got.fim, want.dez, want.unid, want.contando, want.fim);
      else passed++;
    end
  endtask

  initial begin
    main_if.tick = 1'b0; main_if.carrega = 1'b0; main_if.estado = '0; main_if.caso_esp = 1'b0;
    alt_if.tick  = 1'b0; alt_if.carrega  = 1'b0; alt_if.estado  = '0; alt_if.caso_esp  = 1'b0;
    test_reset();
    test_count_norm();
    test_esp_sampling();
    test_back_to_back();
    test_rst_mid();
    test_auto_reload();
    test_clamp_range();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
